collision_detect: RTL and testbench

- Detection stage directly upstream of the game-logic FSM. It computes, once per video frame, whether PacMan overlaps a ghost or an uneaten fruit tile.
- Outputs are single-cycle event pulses that drive the game FSM's LifeDown and Fruit transitions.
- A post-hit grace window, counted in frames, stops one ghost contact from costing several lives.

---
 rtl/pacman_pkg.sv | 33 +++
 rtl/box_overlap.sv | 29 ++
 rtl/collision_detect.sv | 225 ++++++++++++++++++++++
 tb/tb_collision_detect.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared constants and types for the PacMan collision/game-logic path.
//   COORD_W_DEFAULT  default width of all position/size buses
//   GHOST_*          ghost_id encoding (0 = none, 1 red, 2 blue, 3 orange)
//   FRUIT_X0..Y1     inclusive PacMan top-left bounds of each fruit tile,
//                    indexed 0 apple, 1 peas, 2 grapes, 3 drink
//   coll_state_t     collision FSM state
//   in_tile()        inclusive rectangle membership test
package pacman_pkg;

  localparam int COORD_W_DEFAULT = 10;

  localparam logic [1:0] GHOST_NONE   = 2'd0;
  localparam logic [1:0] GHOST_RED    = 2'd1;
  localparam logic [1:0] GHOST_BLUE   = 2'd2;
  localparam logic [1:0] GHOST_ORANGE = 2'd3;

  localparam int unsigned FRUIT_X0 [4] = '{12, 370, 12, 370};
  localparam int unsigned FRUIT_X1 [4] = '{37, 395, 37, 395};
  localparam int unsigned FRUIT_Y0 [4] = '{10, 10, 413, 413};
  localparam int unsigned FRUIT_Y1 [4] = '{35, 35, 438, 438};

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_GRACE = 1'b1
  } coll_state_t;

  function automatic logic in_tile(input int unsigned x, input int unsigned y,
                                   input int unsigned x0, input int unsigned x1,
                                   input int unsigned y0, input int unsigned y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned bounding-box overlap test, purely combinational.
//   i_ax, i_ay, i_asize  top-left corner and edge length of box A
//   i_bx, i_by, i_bsize  top-left corner and edge length of box B
//   o_hit                1 when the interiors intersect; shared edges do not count
module box_overlap #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_ax,
  input  logic [W-1:0] i_ay,
  input  logic [W-1:0] i_asize,
  input  logic [W-1:0] i_bx,
  input  logic [W-1:0] i_by,
  input  logic [W-1:0] i_bsize,
  output logic         o_hit
);

  // One extra bit on the far-edge sums keeps sprites near the screen limit
  // from wrapping back to small coordinates.
  logic [W:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

  assign w_ax_end = {1'b0, i_ax} + {1'b0, i_asize};
  assign w_ay_end = {1'b0, i_ay} + {1'b0, i_asize};
  assign w_bx_end = {1'b0, i_bx} + {1'b0, i_bsize};
  assign w_by_end = {1'b0, i_by} + {1'b0, i_bsize};

  assign o_hit = ({1'b0, i_ax} < w_bx_end) && ({1'b0, i_bx} < w_ax_end) &&
                 ({1'b0, i_ay} < w_by_end) && ({1'b0, i_by} < w_ay_end);

endmodule

// File: rtl/collision_detect.sv
// Per-frame PacMan collision detector feeding the game-logic FSM.
//   Clk, Reset_n         system clock, async active-low reset
//   frame_clk            vsync level, asynchronous to Clk
//   enable               high while the game is running
//   pX,pY,pSize          PacMan box
//   rgX..ogY, gSize      ghost boxes (red, blue, orange)
//   fruits_eaten         eaten flags: apple, peas, grapes, drink
//   ghost_hit/ghost_id   one-cycle ghost event, id held until next event
//   fruit_hit/fruit_idx  one-cycle fruit event, index held until next event
//   grace                post-hit ghost-immunity window active
//
// state    | meaning
// ARMED    | ghost overlaps produce ghost_hit
// GRACE    | ghost overlaps ignored, counting frames down to re-arm
module collision_detect
  import pacman_pkg::*;
#(
  parameter int GRACE_FRAMES = 120,
  parameter int COORD_W      = COORD_W_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               enable,
  input  logic [COORD_W-1:0] pX,
  input  logic [COORD_W-1:0] pY,
  input  logic [COORD_W-1:0] rgX,
  input  logic [COORD_W-1:0] rgY,
  input  logic [COORD_W-1:0] bgX,
  input  logic [COORD_W-1:0] bgY,
  input  logic [COORD_W-1:0] ogX,
  input  logic [COORD_W-1:0] ogY,
  input  logic [COORD_W-1:0] pSize,
  input  logic [COORD_W-1:0] gSize,
  input  logic [3:0]         fruits_eaten,
  output logic               ghost_hit,
  output logic [1:0]         ghost_id,
  output logic               fruit_hit,
  output logic [1:0]         fruit_idx,
  output logic               grace
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_FRAMES);

  logic r_fc_meta, r_fc_sync, r_fc_prev;
  logic w_frame_tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fc_meta <= 1'b0;
      r_fc_sync <= 1'b0;
      r_fc_prev <= 1'b0;
    end else begin
      r_fc_meta <= frame_clk;
      r_fc_sync <= r_fc_meta;
      r_fc_prev <= r_fc_sync;
    end
  end

  assign w_frame_tick = r_fc_sync & ~r_fc_prev;

  // Snapshot taken on the tick edge; r_snap_armed remembers whether the FSM
  // was armed when this frame began, so the tick that ends a grace window
  // does not also evaluate as a hit.
  logic [COORD_W-1:0] r_px, r_py, r_rgx, r_rgy, r_bgx, r_bgy, r_ogx, r_ogy;
  logic [COORD_W-1:0] r_psize, r_gsize;
  logic [3:0]         r_eaten;
  logic               r_snap_vld, r_snap_armed;
  coll_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_px         <= '0;
      r_py         <= '0;
      r_rgx        <= '0;
      r_rgy        <= '0;
      r_bgx        <= '0;
      r_bgy        <= '0;
      r_ogx        <= '0;
      r_ogy        <= '0;
      r_psize      <= '0;
      r_gsize      <= '0;
      r_eaten      <= '0;
      r_snap_vld   <= 1'b0;
      r_snap_armed <= 1'b0;
    end else begin
      r_snap_vld <= w_frame_tick;
      if (w_frame_tick) begin
        r_px         <= pX;
        r_py         <= pY;
        r_rgx        <= rgX;
        r_rgy        <= rgY;
        r_bgx        <= bgX;
        r_bgy        <= bgY;
        r_ogx        <= ogX;
        r_ogy        <= ogY;
        r_psize      <= pSize;
        r_gsize      <= gSize;
        r_eaten      <= fruits_eaten;
        r_snap_armed <= (r_state == ST_ARMED);
      end
    end
  end

  logic w_ov_red, w_ov_blue, w_ov_orange;

  box_overlap #(.W(COORD_W)) u_ov_red (
    .i_ax(r_px), .i_ay(r_py), .i_asize(r_psize),
    .i_bx(r_rgx), .i_by(r_rgy), .i_bsize(r_gsize), .o_hit(w_ov_red)
  );

  box_overlap #(.W(COORD_W)) u_ov_blue (
    .i_ax(r_px), .i_ay(r_py), .i_asize(r_psize),
    .i_bx(r_bgx), .i_by(r_bgy), .i_bsize(r_gsize), .o_hit(w_ov_blue)
  );

  box_overlap #(.W(COORD_W)) u_ov_orange (
    .i_ax(r_px), .i_ay(r_py), .i_asize(r_psize),
    .i_bx(r_ogx), .i_by(r_ogy), .i_bsize(r_gsize), .o_hit(w_ov_orange)
  );

  logic [1:0] w_ghost_sel;
  logic       w_any_ov;

  always_comb begin
    w_ghost_sel = GHOST_NONE;
    if (w_ov_red)         w_ghost_sel = GHOST_RED;
    else if (w_ov_blue)   w_ghost_sel = GHOST_BLUE;
    else if (w_ov_orange) w_ghost_sel = GHOST_ORANGE;
  end

  assign w_any_ov = (w_ghost_sel != GHOST_NONE);

  int unsigned w_px_u, w_py_u;
  logic [3:0]  w_fruit_match;
  logic [1:0]  w_fruit_sel;
  logic        w_fruit_any;

  assign w_px_u = 32'(r_px);
  assign w_py_u = 32'(r_py);

  for (genvar g = 0; g < 4; g++) begin : g_tile
    assign w_fruit_match[g] = in_tile(w_px_u, w_py_u, FRUIT_X0[g], FRUIT_X1[g],
                                      FRUIT_Y0[g], FRUIT_Y1[g]);
  end

  // Tiles are disjoint, so at most one bit can be set here.
  always_comb begin
    w_fruit_sel = 2'd0;
    w_fruit_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (w_fruit_match[i] && !r_eaten[i]) begin
        w_fruit_any = 1'b1;
        w_fruit_sel = 2'(i);
      end
    end
  end

  logic w_ghost_fire, w_fruit_fire;

  assign w_fruit_fire = r_snap_vld & enable & w_fruit_any;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_ARMED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ghost_fire = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_ARMED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (r_snap_vld && r_snap_armed && w_any_ov) begin
            w_ghost_fire = 1'b1;
            w_cnt_nxt    = GRACE_LOAD;
            w_state_nxt  = ST_GRACE;
          end
        end
        ST_GRACE: begin
          if (w_frame_tick) begin
            if (r_cnt <= CNT_W'(1)) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_ARMED;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_ARMED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ghost_hit <= 1'b0;
      ghost_id  <= GHOST_NONE;
      fruit_hit <= 1'b0;
      fruit_idx <= 2'd0;
    end else begin
      ghost_hit <= w_ghost_fire;
      fruit_hit <= w_fruit_fire;
      if (w_ghost_fire) ghost_id  <= w_ghost_sel;
      if (w_fruit_fire) fruit_idx <= w_fruit_sel;
    end
  end

  assign grace = (r_state == ST_GRACE);

endmodule

// File: tb/tb_collision_detect.sv
module tb_collision_detect;

  localparam int G = 3;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_clk, enable;
  logic [9:0] pX, pY, rgX, rgY, bgX, bgY, ogX, ogY, pSize, gSize;
  logic [3:0] fruits_eaten;
  logic       ghost_hit, fruit_hit, grace;
  logic [1:0] ghost_id, fruit_idx;

  collision_detect #(.GRACE_FRAMES(G), .COORD_W(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .enable(enable),
    .pX(pX), .pY(pY), .rgX(rgX), .rgY(rgY), .bgX(bgX), .bgY(bgY),
    .ogX(ogX), .ogY(ogY), .pSize(pSize), .gSize(gSize),
    .fruits_eaten(fruits_eaten), .ghost_hit(ghost_hit), .ghost_id(ghost_id),
    .fruit_hit(fruit_hit), .fruit_idx(fruit_idx), .grace(grace)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: frames of grace left, held ids.
  int m_grace = 0;
  int m_gid   = 0;
  int m_fidx  = 0;

  int tx0 [4] = '{12, 370, 12, 370};
  int tx1 [4] = '{37, 395, 37, 395};
  int ty0 [4] = '{10, 10, 413, 413};
  int ty1 [4] = '{35, 35, 438, 438};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit boxes(int ax, int ay, int as, int bx, int by, int bs);
    return (ax < bx + bs) && (bx < ax + as) && (ay < by + bs) && (by < ay + as);
  endfunction

  function automatic int clip(int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  task automatic scramble_inputs();
    pX = 10'($urandom); pY = 10'($urandom);
    rgX = 10'($urandom); rgY = 10'($urandom);
    bgX = 10'($urandom); bgY = 10'($urandom);
    ogX = 10'($urandom); ogY = 10'($urandom);
    pSize = 10'($urandom_range(1, 64)); gSize = 10'($urandom_range(1, 64));
  endtask

  // One frame: predict, raise frame_clk, watch 8 cycles, compare.
  task automatic run_frame(input string tag, input bit scramble);
    bit exp_gh, exp_fh, eligible;
    int gh_cnt, fh_cnt;
    logic gh4, fh4;
    exp_gh = 0; exp_fh = 0; gh_cnt = 0; fh_cnt = 0; gh4 = 0; fh4 = 0;
    if (enable) begin
      eligible = (m_grace == 0);
      if (m_grace > 0) m_grace--;
      if (eligible) begin
        if (boxes(pX, pY, pSize, rgX, rgY, gSize)) begin exp_gh = 1; m_gid = 1; end
        else if (boxes(pX, pY, pSize, bgX, bgY, gSize)) begin exp_gh = 1; m_gid = 2; end
        else if (boxes(pX, pY, pSize, ogX, ogY, gSize)) begin exp_gh = 1; m_gid = 3; end
        if (exp_gh) m_grace = G;
      end
      for (int i = 0; i < 4; i++)
        if (pX >= tx0[i] && pX <= tx1[i] && pY >= ty0[i] && pY <= ty1[i] && !fruits_eaten[i]) begin
          exp_fh = 1; m_fidx = i;
        end
    end else begin
      m_grace = 0;
    end
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge Clk); #1;
      if (ghost_hit === 1'b1) gh_cnt++;
      if (fruit_hit === 1'b1) fh_cnt++;
      if (c == 4) begin gh4 = ghost_hit; fh4 = fruit_hit; end
      if (c == 3 && scramble) scramble_inputs();
    end
    frame_clk = 1'b0;
    chk({tag, "_ghost_hit_at_T+2"}, 32'(gh4), 32'(exp_gh));
    chk({tag, "_ghost_pulses"}, gh_cnt, exp_gh ? 1 : 0);
    chk({tag, "_fruit_hit_at_T+2"}, 32'(fh4), 32'(exp_fh));
    chk({tag, "_fruit_pulses"}, fh_cnt, exp_fh ? 1 : 0);
    chk({tag, "_ghost_id"}, 32'(ghost_id), m_gid);
    chk({tag, "_fruit_idx"}, 32'(fruit_idx), m_fidx);
    chk({tag, "_grace"}, 32'(grace), (m_grace > 0) ? 1 : 0);
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic drop_enable(input string tag);
    chk({tag, "_grace_before"}, 32'(grace), (m_grace > 0) ? 1 : 0);
    enable = 1'b0;
    @(posedge Clk); #1;
    chk({tag, "_grace_after_enable_low"}, 32'(grace), 0);
    m_grace = 0;
    enable = 1'b1;
  endtask

  task automatic far_ghosts();
    rgX = 700; rgY = 700; bgX = 600; bgY = 600; ogX = 800; ogY = 300;
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; enable = 1'b0;
    pX = 100; pY = 100; pSize = 16; gSize = 16; far_ghosts();
    fruits_eaten = 4'hF;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ghost_hit", 32'(ghost_hit), 0);
    chk("rst_ghost_id", 32'(ghost_id), 0);
    chk("rst_fruit_hit", 32'(fruit_hit), 0);
    chk("rst_fruit_idx", 32'(fruit_idx), 0);
    chk("rst_grace", 32'(grace), 0);
    @(negedge Clk);
    Reset_n = 1'b1; enable = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // Red overlap held across the grace window.
    rgX = 110; rgY = 105;
    run_frame("red_f1", 0);
    run_frame("red_f2", 0);
    run_frame("red_f3", 0);
    run_frame("red_f4", 0);
    run_frame("red_f5", 0);

    // Shared edge vs one-pixel overlap with the blue ghost.
    drop_enable("clr1");
    far_ghosts(); bgX = 116; bgY = 100;
    run_frame("blue_edge", 0);
    bgX = 115;
    run_frame("blue_overlap", 0);

    // Fruit tiles.
    drop_enable("clr2");
    far_ghosts(); pX = 12; pY = 10; fruits_eaten = 4'b0000;
    run_frame("apple", 0);
    fruits_eaten = 4'b0001;
    run_frame("apple_eaten", 0);
    pX = 395; pY = 438; fruits_eaten = 4'b0000;
    run_frame("drink", 0);

    // Ghost and fruit in the same frame, red beats orange.
    pX = 380; pY = 20; rgX = 385; rgY = 25; ogX = 380; ogY = 20;
    run_frame("peas_red", 0);

    // Async reset in the middle of grace.
    chk("pre_reset_grace", 32'(grace), 1);
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_grace", 32'(grace), 0);
    chk("async_rst_ghost_id", 32'(ghost_id), 0);
    chk("async_rst_fruit_idx", 32'(fruit_idx), 0);
    m_grace = 0; m_gid = 0; m_fidx = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    fruits_eaten = 4'hF; pX = 100; pY = 100; far_ghosts(); rgX = 110; rgY = 105;
    run_frame("post_reset", 0);

    // Far-edge sums must not wrap at the top of the coordinate range.
    drop_enable("clr3");
    far_ghosts();
    pX = 1020; pY = 500; pSize = 3; gSize = 20; rgX = 1015; rgY = 495;
    bgX = 0; bgY = 0; ogX = 200; ogY = 200;
    run_frame("wrap", 0);

    // Randomised frames, inputs scrambled after the snapshot edge.
    for (int k = 0; k < 40; k++) begin
      int bx, by;
      bit near_fruit;
      pSize = 10'($urandom_range(1, 32));
      gSize = 10'($urandom_range(1, 32));
      near_fruit = ($urandom_range(0, 9) < 3);
      if (near_fruit) begin
        int t;
        t = $urandom_range(0, 3);
        bx = ($urandom_range(0, 1) == 1) ? tx0[t] : tx1[t];
        by = ($urandom_range(0, 1) == 1) ? ty0[t] : ty1[t];
        bx = clip(bx + $urandom_range(0, 4) - 2);
        by = clip(by + $urandom_range(0, 4) - 2);
      end else begin
        bx = $urandom_range(0, 1023);
        by = $urandom_range(0, 1023);
      end
      pX = 10'(bx); pY = 10'(by);
      rgX = ($urandom_range(0, 1) == 1) ? 10'(clip(bx + $urandom_range(0, 40) - 20)) : 10'($urandom);
      rgY = 10'(clip(by + $urandom_range(0, 40) - 20));
      bgX = 10'(clip(bx + $urandom_range(0, 40) - 20));
      bgY = ($urandom_range(0, 1) == 1) ? 10'(clip(by + $urandom_range(0, 40) - 20)) : 10'($urandom);
      ogX = 10'(clip(bx + $urandom_range(0, 40) - 20));
      ogY = 10'(clip(by + $urandom_range(0, 40) - 20));
      fruits_eaten = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      run_frame("rand", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
